// File: rtl/nibbler_pkg.sv
// Shared opcodes, ALU select codes, FSM states and decode helpers for the Nibbler controller.
// Optional NIBBLER_IO_EN adds the OUT (B) and IN (C) opcodes.
package nibbler_pkg;

    localparam int unsigned OPC_W   = 4;
    localparam int unsigned ALU_S_W = 5;

    localparam logic [ALU_S_W-1:0] ALU_PASSA = 5'b00000;
    localparam logic [ALU_S_W-1:0] ALU_SUB   = 5'b00110;
    localparam logic [ALU_S_W-1:0] ALU_PASSB = 5'b11010;
    localparam logic [ALU_S_W-1:0] ALU_ADD   = 5'b01001;
    localparam logic [ALU_S_W-1:0] ALU_NOR   = 5'b10001;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 4'h0,
        OP_LIT  = 4'h1,
        OP_ADDI = 4'h2,
        OP_SUBI = 4'h3,
        OP_NORI = 4'h4,
        OP_CMPI = 4'h5,
        OP_JC   = 4'h6,
        OP_JNC  = 4'h7,
        OP_JZ   = 4'h8,
        OP_JNZ  = 4'h9,
        OP_JMP  = 4'hA,
        OP_OUT  = 4'hB,
        OP_IN   = 4'hC,
        OP_RD   = 4'hD,
        OP_RE   = 4'hE,
        OP_RF   = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        JADDR  = 3'd3,
        JTAKE  = 3'd4
    } state_t;

    // ALU-side controls held for the single EXEC cycle.
    typedef struct packed {
        logic [ALU_S_W-1:0] s;
        logic               ncin;
        logic               acc_we;
        logic               flag_cap;
`ifdef NIBBLER_IO_EN
        logic               out_we;
`endif
    } alu_ctrl_t;

    function automatic alu_ctrl_t ctrl_idle();
        alu_ctrl_t c;
        c      = '0;
        c.s    = ALU_PASSA;
        c.ncin = 1'b1;
        return c;
    endfunction

    function automatic logic is_jump(input opcode_t op);
        logic j;
        case (op)
            OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_JMP: j = 1'b1;
            default:                              j = 1'b0;
        endcase
        return j;
    endfunction

    function automatic alu_ctrl_t decode_ctrl(input opcode_t op);
        alu_ctrl_t c;
        c = ctrl_idle();
        case (op)
            OP_LIT: begin
                c.s        = ALU_PASSB;
                c.acc_we   = 1'b1;
                c.flag_cap = 1'b1;
            end
            OP_ADDI: begin
                c.s        = ALU_ADD;
                c.acc_we   = 1'b1;
                c.flag_cap = 1'b1;
            end
            OP_SUBI: begin
                c.s        = ALU_SUB;
                c.ncin     = 1'b0;
                c.acc_we   = 1'b1;
                c.flag_cap = 1'b1;
            end
            OP_NORI: begin
                c.s        = ALU_NOR;
                c.acc_we   = 1'b1;
                c.flag_cap = 1'b1;
            end
            OP_CMPI: begin
                c.s        = ALU_SUB;
                c.ncin     = 1'b0;
                c.flag_cap = 1'b1;
            end
`ifdef NIBBLER_IO_EN
            OP_OUT: begin
                c.out_we   = 1'b1;
            end
            OP_IN: begin
                c.s        = ALU_PASSB;
                c.acc_we   = 1'b1;
                c.flag_cap = 1'b1;
            end
`endif
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic jump_taken(input opcode_t op, input logic c, input logic z);
        logic t;
        case (op)
            OP_JC:   t = c;
            OP_JNC:  t = ~c;
            OP_JZ:   t = z;
            OP_JNZ:  t = ~z;
            OP_JMP:  t = 1'b1;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/nibbler_pc.sv
// Program counter register with increment and parallel load; load wins over increment.
module nibbler_pc #(
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          i_inc,
    input  logic          i_load,
    input  logic [AW-1:0] i_load_val,
    output logic [AW-1:0] o_pc
);

    logic [AW-1:0] r_pc;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= r_pc + AW'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/nibbler_ctrl.sv
// Fetch/decode/sequencer for the Nibbler 4-bit CPU: owns pc, ir and C/Z flags, drives the ALU.
// Define NIBBLER_IO_EN to add the OUT/IN opcodes and the out_we/io_in ports.
module nibbler_ctrl
    import nibbler_pkg::*;
#(
    parameter int unsigned AW   = 12,
    parameter int unsigned OP_W = 4
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              run,
    output logic [AW-1:0]     rom_addr,
    input  logic [2*OP_W-1:0] rom_data,
    output logic [4:0]        alu_s,
    output logic              alu_ncin,
    output logic [OP_W-1:0]   alu_b,
    input  logic              alu_cout,
    input  logic              alu_eq,
    output logic              acc_we,
    output logic              c_flag,
    output logic              z_flag,
    output logic [AW-1:0]     pc
`ifdef NIBBLER_IO_EN
    ,
    output logic              out_we,
    input  logic [OP_W-1:0]   io_in
`endif
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2*OP_W-1:0] r_ir;
    logic [2*OP_W-1:0] w_ir_nxt;
    logic             r_c;
    logic             r_z;
    logic             w_c_nxt;
    logic             w_z_nxt;
    alu_ctrl_t        r_ctrl;
    alu_ctrl_t        w_ctrl_nxt;
    logic             w_pc_inc;
    logic             w_pc_load;
    logic [AW-1:0]    w_pc_load_val;
    logic [AW-1:0]    w_pc;
    opcode_t          w_dec_op;
    opcode_t          w_ir_op;

    assign w_dec_op      = opcode_t'(rom_data[2*OP_W-1:OP_W]);
    assign w_ir_op       = opcode_t'(r_ir[2*OP_W-1:OP_W]);
    assign w_pc_load_val = AW'({r_ir[OP_W-1:0], rom_data});

    nibbler_pc #(
        .AW (AW)
    ) u_pc (
        .clk        (clk),
        .nreset     (nreset),
        .i_inc      (w_pc_inc),
        .i_load     (w_pc_load),
        .i_load_val (w_pc_load_val),
        .o_pc       (w_pc)
    );

    // Next-state and datapath control; ALU controls are decoded one cycle early so they
    // come straight from registers during EXEC.
    always_comb begin
        w_state_nxt = r_state;
        w_ir_nxt    = r_ir;
        w_c_nxt     = r_c;
        w_z_nxt     = r_z;
        w_ctrl_nxt  = ctrl_idle();
        w_pc_inc    = 1'b0;
        w_pc_load   = 1'b0;
        case (r_state)
            FETCH: begin
                if (run) begin
                    w_state_nxt = DECODE;
                end
            end
            DECODE: begin
                w_ir_nxt = rom_data;
                w_pc_inc = 1'b1;
                if (is_jump(w_dec_op)) begin
                    w_state_nxt = JADDR;
                end else begin
                    w_state_nxt = EXEC;
                    w_ctrl_nxt  = decode_ctrl(w_dec_op);
                end
            end
            EXEC: begin
                w_state_nxt = FETCH;
                if (r_ctrl.flag_cap) begin
                    w_c_nxt = alu_cout;
                    w_z_nxt = alu_eq;
                end
            end
            JADDR: begin
                w_state_nxt = JTAKE;
            end
            JTAKE: begin
                w_state_nxt = FETCH;
                if (jump_taken(w_ir_op, r_c, r_z)) begin
                    w_pc_load = 1'b1;
                end else begin
                    w_pc_inc  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= FETCH;
            r_ir    <= '0;
            r_c     <= 1'b0;
            r_z     <= 1'b0;
            r_ctrl  <= ctrl_idle();
        end else begin
            r_state <= w_state_nxt;
            r_ir    <= w_ir_nxt;
            r_c     <= w_c_nxt;
            r_z     <= w_z_nxt;
            r_ctrl  <= w_ctrl_nxt;
        end
    end

    // The jump operand lives at pc, which already points past the opcode byte.
    assign rom_addr = w_pc;
    assign pc       = w_pc;
    assign alu_s    = r_ctrl.s;
    assign alu_ncin = r_ctrl.ncin;
    assign acc_we   = r_ctrl.acc_we;
    assign c_flag   = r_c;
    assign z_flag   = r_z;

`ifdef NIBBLER_IO_EN
    assign out_we = r_ctrl.out_we;
    assign alu_b  = (r_state == EXEC && w_ir_op == OP_IN) ? io_in : r_ir[OP_W-1:0];
`else
    assign alu_b  = r_ir[OP_W-1:0];
`endif

endmodule
